// File: rtl/ldm_mem_port.sv
// Memory-side responder for LDM/STM block transfers: bus beat issue, load return, base writeback.
// Optional LDM_MEM_ALIGN_CHK_EN adds o_align_err and suppresses bus beats for a misaligned base.
module ldm_mem_port #(
  parameter int OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        i_blk_start,
  input  logic [31:0] i_base,
  input  logic        i_u,
  input  logic        i_l,
  input  logic        i_w,
  input  logic [4:0]  i_cnt,
  input  logic        i_mem_vld,
  input  logic [31:0] i_offset,
  input  logic [3:0]  i_reg_code,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvld,
  input  logic [31:0] i_bus_rdata,
  output logic [3:0]  o_rf_raddr,
  input  logic [31:0] i_rf_rdata,
  output logic        o_rf_we,
  output logic [3:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_busy
`ifdef LDM_MEM_ALIGN_CHK_EN
  ,
  output logic        o_align_err
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] XFER  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW = $clog2(OUTST + 1);

  logic [1:0]    state;
  logic [31:0]   base_q;
  logic          u_q, l_q, w_q;
  logic [4:0]    cnt_q, beats_left;
  logic [3:0]    fifo [OUTST];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rf_we_q;
  logic [3:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;
  logic          align_q;

  logic        in_xfer, full, take, push, pop, drain_done, store_beat;
  logic [31:0] sum, wb_val;

  // Handshake: a beat transfers when o_bus_req & i_bus_gnt in the same cycle; the sequencer
  // holds the beat while o_stall is high. Load data returns in request order on i_bus_rvld.
  assign in_xfer    = (state == XFER);
  assign full       = (count == CW'(OUTST));
  assign store_beat = in_xfer & ~l_q;
  assign o_bus_req  = i_mem_vld & in_xfer & ~align_q & ~(l_q & full);
  assign take       = align_q ? (i_mem_vld & in_xfer) : (o_bus_req & i_bus_gnt);
  assign o_stall    = i_mem_vld & ~take;
  assign o_bus_we   = o_bus_req & ~l_q;
  assign sum        = u_q ? (base_q + i_offset) : (base_q - i_offset);
  assign o_bus_addr = {sum[31:2], 2'b00};
  assign o_rf_raddr  = store_beat ? i_reg_code : 4'd0;
  assign o_bus_wdata = store_beat ? i_rf_rdata : 32'd0;
  assign wb_val     = u_q ? (base_q + {25'd0, cnt_q, 2'b00}) : (base_q - {25'd0, cnt_q, 2'b00});

  assign push       = en & o_bus_req & i_bus_gnt & l_q;
  assign pop        = en & i_bus_rvld & (count != '0);
  assign drain_done = (count == '0) & ~i_bus_rvld;

  assign o_busy     = (state != IDLE);
  assign o_rf_we    = rf_we_q & en;
  assign o_rf_waddr = rf_waddr_q;
  assign o_rf_wdata = rf_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_q     <= '0;
      u_q        <= 1'b0;
      l_q        <= 1'b0;
      w_q        <= 1'b0;
      cnt_q      <= '0;
      beats_left <= '0;
    end else if (en) begin
      case (state)
        IDLE: if (i_blk_start) begin
          state      <= XFER;
          base_q     <= i_base;
          u_q        <= i_u;
          l_q        <= i_l;
          w_q        <= i_w;
          cnt_q      <= i_cnt;
          beats_left <= i_cnt;
        end
        XFER: if (take) begin
          beats_left <= beats_left - 5'd1;
          if (beats_left == 5'd1) state <= DRAIN;
        end
        // A misaligned block never touched memory, so there is no base update either.
        DRAIN: if (drain_done) state <= align_q ? IDLE : WB;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(OUTST - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(OUTST - 1)) ? '0 : rd_ptr + 1'b1;
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= i_reg_code;
  end

  // Load returns and the base writeback share the write port; they never coincide because
  // DRAIN only exits on a cycle with no returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (en) begin
      if (pop) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= fifo[rd_ptr];
        rf_wdata_q <= i_bus_rdata;
      end else if (state == DRAIN && drain_done && !align_q) begin
        rf_we_q    <= w_q;
        rf_waddr_q <= 4'd0;
        rf_wdata_q <= wb_val;
      end else begin
        rf_we_q    <= 1'b0;
        rf_waddr_q <= '0;
        rf_wdata_q <= '0;
      end
    end
  end

`ifdef LDM_MEM_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  align_q <= 1'b0;
    else if (en && state == IDLE && i_blk_start) align_q <= (i_base[1:0] != 2'b00);
  end
  assign o_align_err = align_q;
`else
  assign align_q = 1'b0;
`endif

endmodule

// File: tb/tb_ldm_mem_port.sv
// Directed bench for ldm_mem_port: loads, stores, FIFO back-pressure, writeback, reset, enable.
// Define LDM_MEM_ALIGN_CHK_EN for both files to exercise the alignment-check build.
module tb_ldm_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        i_blk_start = 1'b0;
  logic [31:0] i_base = '0;
  logic        i_u = 1'b0, i_l = 1'b0, i_w = 1'b0;
  logic [4:0]  i_cnt = '0;
  logic        i_mem_vld = 1'b0;
  logic [31:0] i_offset = '0;
  logic [3:0]  i_reg_code = '0;
  logic        o_stall, o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic        i_bus_gnt = 1'b0, i_bus_rvld = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic [3:0]  o_rf_raddr;
  logic [31:0] i_rf_rdata;
  logic        o_rf_we;
  logic [3:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_busy;
`ifdef LDM_MEM_ALIGN_CHK_EN
  logic        o_align_err;
`endif

  int errors = 0;
  int checks = 0;

  // Register file model: register n reads as 0xA000000n.
  assign i_rf_rdata = {28'hA000000, o_rf_raddr};

  ldm_mem_port #(.OUTST(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .i_blk_start(i_blk_start), .i_base(i_base),
    .i_u(i_u), .i_l(i_l), .i_w(i_w), .i_cnt(i_cnt), .i_mem_vld(i_mem_vld),
    .i_offset(i_offset), .i_reg_code(i_reg_code), .o_stall(o_stall), .o_bus_req(o_bus_req),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_gnt(i_bus_gnt), .i_bus_rvld(i_bus_rvld), .i_bus_rdata(i_bus_rdata),
    .o_rf_raddr(o_rf_raddr), .i_rf_rdata(i_rf_rdata), .o_rf_we(o_rf_we),
    .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata), .o_busy(o_busy)
`ifdef LDM_MEM_ALIGN_CHK_EN
    , .o_align_err(o_align_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic start(input logic [31:0] base, input logic u, input logic l, input logic w,
                       input logic [4:0] cnt);
    @(negedge clk);
    i_blk_start = 1'b1; i_base = base; i_u = u; i_l = l; i_w = w; i_cnt = cnt;
    i_mem_vld = 1'b0; i_bus_rvld = 1'b0;
  endtask

  // One cycle of sequencer/bus stimulus; outputs are sampled 1ns after the falling edge.
  task automatic drive(input logic vld, input logic [31:0] off, input logic [3:0] code,
                       input logic gnt, input logic rvld, input logic [31:0] rdata);
    @(negedge clk);
    i_blk_start = 1'b0; i_mem_vld = vld; i_offset = off; i_reg_code = code;
    i_bus_gnt = gnt; i_bus_rvld = rvld; i_bus_rdata = rdata;
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%h exp=0", o_busy); end
    checks++; if (o_rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got=%h exp=0", o_rf_we); end
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%h exp=0", o_bus_req); end
    checks++; if (o_bus_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got=%h exp=0", o_bus_addr); end
    checks++; if (o_rf_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", o_rf_wdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ldmia();
    start(32'h1000, 1'b1, 1'b1, 1'b0, 5'd3);
    drive(1'b1, 32'd0, 4'd1, 1'b1, 1'b0, 32'd0);
    checks++; if (o_bus_req !== 1'b1) begin errors++; $display("FAIL ld_req0 got=%h exp=1", o_bus_req); end
    checks++; if (o_bus_addr !== 32'h1000) begin errors++; $display("FAIL ld_addr0 got=%h exp=1000", o_bus_addr); end
    checks++; if (o_bus_we !== 1'b0) begin errors++; $display("FAIL ld_we got=%h exp=0", o_bus_we); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL ld_stall got=%h exp=0", o_stall); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ld_busy got=%h exp=1", o_busy); end
    drive(1'b1, 32'd4, 4'd2, 1'b1, 1'b1, 32'hD1);
    checks++; if (o_bus_addr !== 32'h1004) begin errors++; $display("FAIL ld_addr1 got=%h exp=1004", o_bus_addr); end
    drive(1'b1, 32'd8, 4'd5, 1'b1, 1'b1, 32'hD2);
    checks++; if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h1008) begin errors++; $display("FAIL ld_beat2 got=%h/%h exp=1/1008", o_bus_req, o_bus_addr); end
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd1, 32'hD1}) begin errors++; $display("FAIL ld_wr_r1 got=%h/%h/%h exp=1/1/d1", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'hD5);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd2, 32'hD2}) begin errors++; $display("FAIL ld_wr_r2 got=%h/%h/%h exp=1/2/d2", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd5, 32'hD5}) begin errors++; $display("FAIL ld_wr_r5 got=%h/%h/%h exp=1/5/d5", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b1 || o_rf_we !== 1'b0) begin errors++; $display("FAIL ld_wb_nowrite got=%h/%h exp=1/0", o_busy, o_rf_we); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ld_idle got=%h exp=0", o_busy); end
  endtask

  task automatic test_stmdb();
    start(32'h2000, 1'b0, 1'b0, 1'b1, 5'd2);
    drive(1'b1, 32'd4, 4'd7, 1'b0, 1'b0, 32'd0);
    checks++; if (o_bus_req !== 1'b1 || o_stall !== 1'b1) begin errors++; $display("FAIL st_nognt got=%h/%h exp=1/1", o_bus_req, o_stall); end
    drive(1'b1, 32'd4, 4'd7, 1'b1, 1'b0, 32'd0);
    checks++; if (o_bus_addr !== 32'h1FFC || o_bus_we !== 1'b1) begin errors++; $display("FAIL st_beat0 got=%h/%h exp=1ffc/1", o_bus_addr, o_bus_we); end
    checks++; if (o_rf_raddr !== 4'd7 || o_bus_wdata !== 32'hA0000007) begin errors++; $display("FAIL st_data0 got=%h/%h exp=7/a0000007", o_rf_raddr, o_bus_wdata); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL st_stall got=%h exp=0", o_stall); end
    drive(1'b1, 32'd8, 4'd3, 1'b1, 1'b0, 32'd0);
    checks++; if (o_bus_addr !== 32'h1FF8 || o_bus_wdata !== 32'hA0000003) begin errors++; $display("FAIL st_beat1 got=%h/%h exp=1ff8/a0000003", o_bus_addr, o_bus_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b1 || o_rf_we !== 1'b0) begin errors++; $display("FAIL st_drain got=%h/%h exp=1/0", o_busy, o_rf_we); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd0, 32'h1FF8}) begin errors++; $display("FAIL st_wb got=%h/%h/%h exp=1/0/1ff8", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b0 || o_rf_we !== 1'b0) begin errors++; $display("FAIL st_idle got=%h/%h exp=0/0", o_busy, o_rf_we); end
  endtask

  task automatic test_back_pressure();
    start(32'h3000, 1'b1, 1'b1, 1'b0, 5'd4);
    drive(1'b1, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 32'd4, 4'd1, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 32'd8, 4'd2, 1'b1, 1'b0, 32'd0);
    checks++; if (o_bus_req !== 1'b0 || o_stall !== 1'b1) begin errors++; $display("FAIL bp_full0 got=%h/%h exp=0/1", o_bus_req, o_stall); end
    drive(1'b1, 32'd8, 4'd2, 1'b1, 1'b0, 32'd0);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL bp_full1 got=%h exp=1", o_stall); end
    drive(1'b1, 32'd8, 4'd2, 1'b1, 1'b1, 32'hE0);
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL bp_full_rvld got=%h exp=0", o_bus_req); end
    drive(1'b1, 32'd8, 4'd2, 1'b1, 1'b1, 32'hE1);
    checks++; if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h3008) begin errors++; $display("FAIL bp_resume got=%h/%h exp=1/3008", o_bus_req, o_bus_addr); end
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd0, 32'hE0}) begin errors++; $display("FAIL bp_wr_r0 got=%h/%h/%h exp=1/0/e0", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b1, 32'd12, 4'd3, 1'b1, 1'b1, 32'hE2);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd1, 32'hE1}) begin errors++; $display("FAIL bp_wr_r1 got=%h/%h/%h exp=1/1/e1", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'hE3);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd2, 32'hE2}) begin errors++; $display("FAIL bp_wr_r2 got=%h/%h/%h exp=1/2/e2", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd3, 32'hE3}) begin errors++; $display("FAIL bp_wr_r3 got=%h/%h/%h exp=1/3/e3", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_idle got=%h exp=0", o_busy); end
  endtask

  task automatic test_writeback();
    start(32'h100, 1'b1, 1'b1, 1'b1, 5'd2);
    drive(1'b1, 32'd0, 4'd4, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 32'd4, 4'd6, 1'b1, 1'b1, 32'h44);
    drive(1'b0, 32'd0, 4'd0, 1'b1, 1'b1, 32'h66);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd4, 32'h44}) begin errors++; $display("FAIL wb_wr_r4 got=%h/%h/%h exp=1/4/44", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd6, 32'h66}) begin errors++; $display("FAIL wb_wr_r6 got=%h/%h/%h exp=1/6/66", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 4'd0, 32'h108}) begin errors++; $display("FAIL wb_base got=%h/%h/%h exp=1/0/108", o_rf_we, o_rf_waddr, o_rf_wdata); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b0 || o_rf_we !== 1'b0) begin errors++; $display("FAIL wb_idle got=%h/%h exp=0/0", o_busy, o_rf_we); end
  endtask

  task automatic test_reset_mid();
    start(32'h4000, 1'b1, 1'b1, 1'b0, 5'd2);
    drive(1'b1, 32'd0, 4'd9, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%h exp=0", o_busy); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b1, 32'hBAD);
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_rf_we !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rm_stale got=%h/%h exp=0/0", o_rf_we, o_busy); end
  endtask

  task automatic test_enable();
    @(negedge clk);
    en = 1'b0; i_blk_start = 1'b1; i_base = 32'h500; i_l = 1'b1; i_cnt = 5'd1;
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL en_frozen got=%h exp=0", o_busy); end
    en = 1'b1;
  endtask

  task automatic test_align();
`ifdef LDM_MEM_ALIGN_CHK_EN
    start(32'h1002, 1'b1, 1'b1, 1'b1, 5'd2);
    drive(1'b1, 32'd0, 4'd1, 1'b1, 1'b0, 32'd0);
    checks++; if (o_bus_req !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL al_beat0 got=%h/%h exp=0/0", o_bus_req, o_stall); end
    checks++; if (o_align_err !== 1'b1) begin errors++; $display("FAIL al_err got=%h exp=1", o_align_err); end
    drive(1'b1, 32'd4, 4'd2, 1'b1, 1'b0, 32'd0);
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL al_beat1 got=%h exp=0", o_bus_req); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_rf_we !== 1'b0) begin errors++; $display("FAIL al_drain_we got=%h exp=0", o_rf_we); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b0 || o_rf_we !== 1'b0 || o_align_err !== 1'b1) begin errors++; $display("FAIL al_end got=%h/%h/%h exp=0/0/1", o_busy, o_rf_we, o_align_err); end
`else
    start(32'h1002, 1'b1, 1'b0, 1'b0, 5'd1);
    drive(1'b1, 32'd0, 4'd1, 1'b1, 1'b0, 32'd0);
    checks++; if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h1000) begin errors++; $display("FAIL al_ignored got=%h/%h exp=1/1000", o_bus_req, o_bus_addr); end
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL al_idle got=%h exp=0", o_busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb();
    test_back_pressure();
    test_writeback();
    test_reset_mid();
    test_enable();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
